// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES round sequencer: sequencer states and the
// default round count / round-index width.
// No ports.
package aes_seq_pkg;

  localparam int NUM_ROUNDS_DEF = 10;
  localparam int CNT_W_DEF      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/aes_round_counter.sv
// Round counter for the AES sequencer: synchronous load, increment on enable,
// and a terminal flag raised when the count equals TERM.
// Ports:
//   clk, rst            clock, async active-high reset (count -> 0)
//   load_i, load_val_i  load count with load_val_i (wins over inc_i)
//   inc_i               increment count by one
//   count_o             current count
//   term_o              count_o == TERM
module aes_round_counter
  import aes_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TERM  = NUM_ROUNDS_DEF - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == CNT_W'(TERM));

endmodule

// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES datapath. Accepts one block at a
// time, steps the datapath through the initial AddRoundKey, the middle
// rounds and the final round (waiting on the key schedule each step), then
// holds the finished block until the consumer takes it.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid, in_decrypt, in_ready block offer, its mode, accept possible
//   key_ready                      round key for key_sel available this cycle
//   load_state                     datapath captures the input block
//   round_en                       datapath performs one round operation
//   first_round, final_round       qualifiers: AddRoundKey only / no MixColumns
//   round_idx, key_sel             logical round, round-key index
//   out_valid, out_ready           finished block handshake
//   busy                           not idle
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// INIT  | initial AddRoundKey (round 0)
// ROUND | middle rounds 1..NUM_ROUNDS-1, index from the round counter
// FINAL | last round (NUM_ROUNDS), MixColumns omitted
// DONE  | finished block held on out_valid until out_ready
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_decrypt,
  output logic             in_ready,
  input  logic             key_ready,
  output logic             load_state,
  output logic             round_en,
  output logic             first_round,
  output logic             final_round,
  output logic [CNT_W-1:0] round_idx,
  output logic [CNT_W-1:0] key_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  logic             cnt_load, cnt_inc, cnt_term;
  logic [CNT_W-1:0] cnt_load_val, cnt;

  // INIT hands the counter round 1; FINAL clears it for the next block.
  assign cnt_load     = key_ready && ((state_q == ST_INIT) || (state_q == ST_FINAL));
  assign cnt_load_val = (state_q == ST_INIT) ? CNT_W'(1) : '0;
  assign cnt_inc      = key_ready && (state_q == ST_ROUND);

  aes_round_counter #(
    .CNT_W (CNT_W),
    .TERM  (NUM_ROUNDS - 1)
  ) u_round_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .count_o    (cnt),
    .term_o     (cnt_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d  = in_decrypt;
          state_d = ST_INIT;
        end
      end
      ST_INIT:  if (key_ready) state_d = ST_ROUND;
      ST_ROUND: if (key_ready && cnt_term) state_d = ST_FINAL;
      ST_FINAL: if (key_ready) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // first_round/final_round mark which kind of step is in progress; round_en
  // says whether it executes this cycle (low while the key schedule stalls).
  always_comb begin
    in_ready    = 1'b0;
    load_state  = 1'b0;
    round_en    = 1'b0;
    first_round = 1'b0;
    final_round = 1'b0;
    round_idx   = '0;
    key_sel     = '0;
    out_valid   = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        in_ready   = 1'b1;
        // Reset forces IDLE asynchronously; keep the capture strobe quiet there.
        load_state = in_valid && !rst;
      end
      ST_INIT: begin
        first_round = 1'b1;
        round_en    = key_ready;
      end
      ST_ROUND: begin
        round_idx = cnt;
        round_en  = key_ready;
      end
      ST_FINAL: begin
        round_idx   = CNT_W'(NUM_ROUNDS);
        final_round = 1'b1;
        round_en    = key_ready;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
    // Decrypt walks the key schedule backwards; uses the latched mode only.
    if ((state_q == ST_INIT) || (state_q == ST_ROUND) || (state_q == ST_FINAL)) begin
      key_sel = mode_q ? (CNT_W'(NUM_ROUNDS) - round_idx) : round_idx;
    end
  end

endmodule
